// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle RV32 instruction sequencer with bus watchdog
module core_sequencer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             halt_i,
   output logic             imem_req_o,
   input  logic             imem_gnt_i,
   input  logic             imem_rvalid_i,
   output logic             dmem_req_o,
   output logic             dmem_we_o,
   input  logic             dmem_gnt_i,
   input  logic             dmem_rvalid_i,
   input  logic             dec_valid_i,
   input  logic             dec_we_i,
   input  logic             dec_rf_we_i,
   input  logic             dec_wb_sel_i,
   input  logic             dec_b_i,
   input  logic             dec_j_i,
   input  logic             branch_taken_i,
   output logic             ir_we_o,
   output logic             exec_en_o,
   output logic             rf_we_o,
   output logic             pc_we_o,
   output logic             pc_sel_o,
   output logic             retire_o,
   output logic             illegal_o,
   output logic             bus_err_o,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] instret_o
);

   typedef enum logic [2:0] {
      S_FETCH_REQ  = 3'd0,
      S_FETCH_WAIT = 3'd1,
      S_DECODE     = 3'd2,
      S_EXECUTE    = 3'd3,
      S_MEM_REQ    = 3'd4,
      S_MEM_WAIT   = 3'd5,
      S_WRITEBACK  = 3'd6,
      S_HALT       = 3'd7
   } state_t;

   // Counter must be able to hold MEM_TIMEOUT-1; the timeout fires on the
   // edge that would take it to MEM_TIMEOUT.
   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST =
      (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;
   localparam bit WDOG_EN = (MEM_TIMEOUT > 0);

   state_t             state_q;
   state_t             state_d;
   logic [WAIT_W-1:0]  wait_q;
   logic               illegal_q;
   logic               bus_err_q;
   logic [CNT_W-1:0]   instret_q;
   logic               wait_active;
   logic               wait_expired;
   logic               set_illegal;
   logic               set_bus_err;

   // Next-state decode and combinational strobes; exit conditions beat the watchdog.
   always_comb begin
      state_d      = state_q;
      imem_req_o   = 1'b0;
      dmem_req_o   = 1'b0;
      dmem_we_o    = 1'b0;
      ir_we_o      = 1'b0;
      exec_en_o    = 1'b0;
      rf_we_o      = 1'b0;
      pc_we_o      = 1'b0;
      pc_sel_o     = 1'b0;
      retire_o     = 1'b0;
      wait_active  = 1'b0;
      set_illegal  = 1'b0;
      set_bus_err  = 1'b0;
      wait_expired = WDOG_EN && (wait_q == WAIT_LAST);
      case (state_q)
         S_FETCH_REQ: begin
            imem_req_o = !halt_i;
            if (!halt_i) begin
               wait_active = 1'b1;
               if (imem_gnt_i) begin
                  state_d = S_FETCH_WAIT;
               end else if (wait_expired) begin
                  state_d     = S_HALT;
                  set_bus_err = 1'b1;
               end
            end
         end
         S_FETCH_WAIT: begin
            wait_active = 1'b1;
            if (imem_rvalid_i) begin
               ir_we_o = 1'b1;
               state_d = S_DECODE;
            end else if (wait_expired) begin
               state_d     = S_HALT;
               set_bus_err = 1'b1;
            end
         end
         S_DECODE: begin
            if (!dec_valid_i) begin
               state_d     = S_HALT;
               set_illegal = 1'b1;
            end else begin
               state_d = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            exec_en_o = 1'b1;
            state_d   = (dec_we_i || dec_wb_sel_i) ? S_MEM_REQ : S_WRITEBACK;
         end
         S_MEM_REQ: begin
            dmem_req_o  = 1'b1;
            dmem_we_o   = dec_we_i;
            wait_active = 1'b1;
            if (dmem_gnt_i) begin
               state_d = S_MEM_WAIT;
            end else if (wait_expired) begin
               state_d     = S_HALT;
               set_bus_err = 1'b1;
            end
         end
         S_MEM_WAIT: begin
            wait_active = 1'b1;
            if (dmem_rvalid_i) begin
               state_d = S_WRITEBACK;
            end else if (wait_expired) begin
               state_d     = S_HALT;
               set_bus_err = 1'b1;
            end
         end
         S_WRITEBACK: begin
            rf_we_o  = dec_rf_we_i;
            pc_we_o  = 1'b1;
            pc_sel_o = dec_j_i | (dec_b_i & branch_taken_i);
            retire_o = 1'b1;
            state_d  = S_FETCH_REQ;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_HALT;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_FETCH_REQ;
      end else begin
         state_q <= state_d;
      end
   end

   // Watchdog wait counter: restarts on every state change, holds while halted in fetch.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wait_q <= '0;
      end else if (state_d != state_q) begin
         wait_q <= '0;
      end else if (wait_active) begin
         wait_q <= wait_q + 1'b1;
      end
   end

   // Sticky fault flags, cleared only by reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         if (set_illegal) illegal_q <= 1'b1;
         if (set_bus_err) bus_err_q <= 1'b1;
      end
   end

   // Retired-instruction counter, wraps naturally at 2^CNT_W.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         instret_q <= '0;
      end else if (retire_o) begin
         instret_q <= instret_q + 1'b1;
      end
   end

   assign illegal_o = illegal_q;
   assign bus_err_o = bus_err_q;
   assign instret_o = instret_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - self-checking bench for core_sequencer
module tb_core_sequencer;

   localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BRANCH = 3, K_JUMP = 4;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b1;
   logic        halt_i = 1'b0;
   logic        imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
   logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
   logic        dec_valid_i = 1'b1, dec_we_i = 1'b0, dec_rf_we_i = 1'b0;
   logic        dec_wb_sel_i = 1'b0, dec_b_i = 1'b0, dec_j_i = 1'b0;
   logic        branch_taken_i = 1'b0;

   logic        imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, exec_en_o;
   logic        rf_we_o, pc_we_o, pc_sel_o, retire_o, illegal_o, bus_err_o;
   logic [2:0]  state_o;
   logic [31:0] instret_o;

   logic        imem_req_s, dmem_req_s, dmem_we_s, ir_we_s, exec_en_s;
   logic        rf_we_s, pc_we_s, pc_sel_s, retire_s, illegal_s, bus_err_s;
   logic [2:0]  state_s;
   logic [2:0]  instret_s;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] model_instret = 0;
   bit          small_ok = 1'b1;

   core_sequencer #(.MEM_TIMEOUT(16), .CNT_W(32)) u_dut (
      .clk_i(clk), .rst_ni(rst_ni), .halt_i(halt_i),
      .imem_req_o(imem_req_o), .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_gnt_i(dmem_gnt_i),
      .dmem_rvalid_i(dmem_rvalid_i), .dec_valid_i(dec_valid_i), .dec_we_i(dec_we_i),
      .dec_rf_we_i(dec_rf_we_i), .dec_wb_sel_i(dec_wb_sel_i), .dec_b_i(dec_b_i),
      .dec_j_i(dec_j_i), .branch_taken_i(branch_taken_i), .ir_we_o(ir_we_o),
      .exec_en_o(exec_en_o), .rf_we_o(rf_we_o), .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o),
      .retire_o(retire_o), .illegal_o(illegal_o), .bus_err_o(bus_err_o),
      .state_o(state_o), .instret_o(instret_o)
   );

   // Narrow counter, watchdog disabled: shares all stimulus with the main instance.
   core_sequencer #(.MEM_TIMEOUT(0), .CNT_W(3)) u_small (
      .clk_i(clk), .rst_ni(rst_ni), .halt_i(halt_i),
      .imem_req_o(imem_req_s), .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
      .dmem_req_o(dmem_req_s), .dmem_we_o(dmem_we_s), .dmem_gnt_i(dmem_gnt_i),
      .dmem_rvalid_i(dmem_rvalid_i), .dec_valid_i(dec_valid_i), .dec_we_i(dec_we_i),
      .dec_rf_we_i(dec_rf_we_i), .dec_wb_sel_i(dec_wb_sel_i), .dec_b_i(dec_b_i),
      .dec_j_i(dec_j_i), .branch_taken_i(branch_taken_i), .ir_we_o(ir_we_s),
      .exec_en_o(exec_en_s), .rf_we_o(rf_we_s), .pc_we_o(pc_we_s), .pc_sel_o(pc_sel_s),
      .retire_o(retire_s), .illegal_o(illegal_s), .bus_err_o(bus_err_s),
      .state_o(state_s), .instret_o(instret_s)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [13:0] obs_vec();
      return {state_o, imem_req_o, ir_we_o, exec_en_o, dmem_req_o, dmem_we_o,
              rf_we_o, pc_we_o, pc_sel_o, retire_o, illegal_o, bus_err_o};
   endfunction

   function automatic logic [13:0] ev(input logic [2:0] st, input logic imr, irw, exe,
                                      dr, dw, rfw, pcw, pcs, ret, ill, be);
      return {st, imr, irw, exe, dr, dw, rfw, pcw, pcs, ret, ill, be};
   endfunction

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   // One clock: drive inputs just after the falling edge, sample 1ns later.
   task automatic step(input logic ig, iv, dg, dv, h, input logic [13:0] exp, input string tag);
      logic [2:0] exp_st;
      @(negedge clk);
      imem_gnt_i = ig; imem_rvalid_i = iv; dmem_gnt_i = dg; dmem_rvalid_i = dv; halt_i = h;
      #1;
      chk(tag, obs_vec(), exp);
      exp_st = exp[13:11];
      if (small_ok) chk({tag, "_small"}, state_s, exp_st);
   endtask

   task automatic set_dec(input int kind, input bit taken);
      dec_valid_i    = 1'b1;
      dec_we_i       = (kind == K_STORE);
      dec_wb_sel_i   = (kind == K_LOAD);
      dec_rf_we_i    = (kind == K_ALU) || (kind == K_LOAD) || (kind == K_JUMP);
      dec_b_i        = (kind == K_BRANCH);
      dec_j_i        = (kind == K_JUMP);
      branch_taken_i = taken;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      halt_i = 1'b0;
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
      #1;
      chk("rst_outputs", obs_vec(), ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("rst_instret", instret_o, 0);
      chk("rst_instret_small", instret_s, 0);
      repeat (2) @(posedge clk);
      @(posedge clk);
      #1 rst_ni = 1'b1;
      model_instret = 0;
      small_ok = 1'b1;
   endtask

   // Reference: an instruction is a list of phases whose lengths follow from memory waits.
   task automatic run_instr(input int kind, input bit taken, input int gfi, rfi, gdm, rdm,
                            input string tag, output int lat, output int dreq_cyc);
      int ph[$];
      bit mem, store, rfw, pcs, last;
      logic [2:0] st;
      logic [2:0] small_exp;
      set_dec(kind, taken);
      mem   = (kind == K_LOAD) || (kind == K_STORE);
      store = (kind == K_STORE);
      rfw   = (kind == K_ALU) || (kind == K_LOAD) || (kind == K_JUMP);
      pcs   = (kind == K_JUMP) || (kind == K_BRANCH && taken);
      for (int i = 0; i <= gfi; i++) ph.push_back(0);
      for (int i = 0; i <= rfi; i++) ph.push_back(1);
      ph.push_back(2);
      ph.push_back(3);
      if (mem) begin
         for (int i = 0; i <= gdm; i++) ph.push_back(4);
         for (int i = 0; i <= rdm; i++) ph.push_back(5);
      end
      ph.push_back(6);
      lat = -1;
      dreq_cyc = 0;
      for (int i = 0; i < ph.size(); i++) begin
         st   = 3'(ph[i]);
         last = (i == ph.size() - 1) || (ph[i + 1] != ph[i]);
         step((st == 3'd0) ? last : rnd(), (st == 3'd1) ? last : rnd(),
              (st == 3'd4) ? last : rnd(), (st == 3'd5) ? last : rnd(), 1'b0,
              ev(st, st == 3'd0, st == 3'd1 && last, st == 3'd3, st == 3'd4,
                 st == 3'd4 && store, st == 3'd6 && rfw, st == 3'd6, st == 3'd6 && pcs,
                 st == 3'd6, 1'b0, 1'b0), tag);
         if (retire_o === 1'b1 && lat < 0) lat = i + 1;
         if (dmem_req_o === 1'b1) dreq_cyc++;
      end
      model_instret = model_instret + 1;
      @(posedge clk);
      #1;
      chk({tag, "_instret"}, instret_o, model_instret);
      small_exp = 3'(model_instret % 8);
      if (small_ok) chk({tag, "_instret_wrap"}, instret_s, small_exp);
   endtask

   initial begin
      int lat, dq, kind, gfi, rfi, gdm, rdm, exp_lat;
      bit tk;

      #2;
      do_reset();

      // ADD, zero-wait memory
      run_instr(K_ALU, 1'b0, 0, 0, 0, 0, "add", lat, dq);
      chk("add_latency", lat, 5);

      // LW zero-wait, then LW with grant 3 cycles late and rvalid 2 cycles late
      run_instr(K_LOAD, 1'b0, 0, 0, 0, 0, "lw0", lat, dq);
      chk("lw0_latency", lat, 7);
      run_instr(K_LOAD, 1'b0, 0, 0, 3, 2, "lw_slow", lat, dq);
      chk("lw_slow_latency", lat, 12);
      chk("lw_slow_req_cycles", dq, 4);

      // Branches and store
      run_instr(K_BRANCH, 1'b1, 0, 0, 0, 0, "beq_taken", lat, dq);
      run_instr(K_BRANCH, 1'b0, 0, 0, 0, 0, "beq_not", lat, dq);
      run_instr(K_STORE, 1'b0, 1, 1, 1, 1, "sw", lat, dq);
      run_instr(K_JUMP, 1'b0, 0, 2, 0, 0, "jal", lat, dq);

      // Randomized instruction stream; narrow counter wraps along the way
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 4);
         tk   = rnd();
         gfi  = $urandom_range(0, 3);
         rfi  = $urandom_range(0, 3);
         gdm  = $urandom_range(0, 3);
         rdm  = $urandom_range(0, 3);
         run_instr(kind, tk, gfi, rfi, gdm, rdm, "rand", lat, dq);
         exp_lat = 5 + gfi + rfi + ((kind == K_LOAD || kind == K_STORE) ? 2 + gdm + rdm : 0);
         chk("rand_latency", lat, exp_lat);
      end

      // halt_i held in FETCH_REQ for 20 cycles, then released
      for (int i = 0; i < 20; i++)
         step(rnd(), rnd(), rnd(), rnd(), 1'b1, ev(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "halt_hold");
      run_instr(K_ALU, 1'b0, 0, 0, 0, 0, "after_halt", lat, dq);
      chk("after_halt_latency", lat, 5);

      // Reset in the middle of a load (async, no writeback)
      set_dec(K_LOAD, 1'b0);
      step(1, 0, 0, 0, 0, ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "midrst");
      step(0, 1, 0, 0, 0, ev(3'd1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "midrst");
      step(0, 0, 0, 0, 0, ev(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "midrst");
      step(0, 0, 0, 0, 0, ev(3'd3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "midrst");
      step(0, 0, 1, 0, 0, ev(3'd4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "midrst");
      step(0, 0, 0, 0, 0, ev(3'd5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "midrst");
      do_reset();
      run_instr(K_LOAD, 1'b0, 0, 0, 0, 0, "post_rst", lat, dq);

      // Illegal opcode: absorbing HALT for 100 cycles
      set_dec(K_ALU, 1'b0);
      dec_valid_i = 1'b0;
      step(1, 0, 0, 0, 0, ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "illegal");
      step(0, 1, 0, 0, 0, ev(3'd1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "illegal");
      step(0, 0, 0, 0, 0, ev(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "illegal");
      for (int i = 0; i < 100; i++)
         step(rnd(), rnd(), rnd(), rnd(), rnd(), ev(3'd7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "illegal_halt");
      do_reset();
      run_instr(K_ALU, 1'b0, 0, 0, 0, 0, "after_illegal", lat, dq);

      // Data grant never arrives: bus fault 16 cycles after entering MEM_REQ
      set_dec(K_LOAD, 1'b0);
      step(1, 0, 0, 0, 0, ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "tmo");
      step(0, 1, 0, 0, 0, ev(3'd1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "tmo");
      step(0, 0, 0, 0, 0, ev(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "tmo");
      step(0, 0, 0, 0, 0, ev(3'd3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "tmo");
      for (int i = 0; i < 16; i++)
         step(0, 0, 0, rnd(), 0, ev(3'd4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "tmo_wait");
      small_ok = 1'b0;
      step(0, 0, 0, 0, 0, ev(3'd7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "tmo_fault");
      chk("tmo_disabled_state", state_s, 3'd4);
      chk("tmo_disabled_buserr", bus_err_s, 1'b0);
      for (int i = 0; i < 5; i++)
         step(1, 1, 1, 1, 0, ev(3'd7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "tmo_absorb");
      do_reset();

      // Exit on the last permitted cycle of every wait state takes priority
      run_instr(K_LOAD, 1'b0, 15, 15, 15, 15, "edge_gnt", lat, dq);
      chk("edge_gnt_latency", lat, 5 + 15 + 15 + 2 + 15 + 15);
      chk("edge_gnt_req_cycles", dq, 16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle sequencer for the RV32 core: steps each instruction through fetch, decode, execute, optional memory access and writeback. It drives the instruction-register, PC, register-file and data-memory enables. It consumes the decoder's per-instruction control outputs and the ALU compare result, and handshakes with separate instruction and data memory ports. It also provides a bus-timeout watchdog, sticky fault flags and a retired-instruction counter.

## Interface
- MEM_TIMEOUT, 16: max cycles spent in any one memory state before a bus fault; 0 disables the watchdog
- CNT_W, 32: width of instret_o

- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- halt_i  in  1  hold at the next instruction boundary while high
- imem_req_o  out  1  instruction fetch request
- imem_gnt_i  in  1  fetch request accepted
- imem_rvalid_i  in  1  fetch data valid
- dmem_req_o  out  1  data access request
- dmem_we_o  out  1  data access is a store
- dmem_gnt_i  in  1  data request accepted
- dmem_rvalid_i  in  1  load data valid / store acknowledged
- dec_valid_i  in  1  decoder recognised the opcode
- dec_we_i, dec_rf_we_i, dec_wb_sel_i, dec_b_i, dec_j_i  in  1 each  decoder control outputs (memory write, RF write, writeback-from-memory, branch, jump)
- branch_taken_i  in  1  ALU compare result
- ir_we_o  out  1  latch fetched instruction
- exec_en_o  out  1  latch ALU result / target address
- rf_we_o  out  1  register-file write strobe
- pc_we_o  out  1  PC update strobe
- pc_sel_o  out  1  0 = PC+4, 1 = branch/jump target
- retire_o  out  1  instruction retired pulse
- illegal_o  out  1  sticky illegal-opcode fault
- bus_err_o  out  1  sticky memory timeout fault
- state_o  out  3  current state encoding
- instret_o  out  CNT_W  retired-instruction count

## Operation
- State encodings:
  - FETCH_REQ = 0
  - FETCH_WAIT = 1
  - DECODE = 2
  - EXECUTE = 3
  - MEM_REQ = 4
  - MEM_WAIT = 5
  - WRITEBACK = 6
  - HALT = 7
- FETCH_REQ:
  - imem_req_o = !halt_i.
  - If imem_gnt_i && !halt_i, go to FETCH_WAIT. Otherwise stay.
- FETCH_WAIT: on imem_rvalid_i, pulse ir_we_o and go to DECODE.
- DECODE:
  - If !dec_valid_i, go to HALT and set illegal_o.
  - Otherwise go to EXECUTE.
- EXECUTE:
  - Pulse exec_en_o.
  - If dec_we_i or dec_wb_sel_i, go to MEM_REQ. Otherwise go to WRITEBACK.
- MEM_REQ:
  - dmem_req_o = 1 and dmem_we_o = dec_we_i.
  - On dmem_gnt_i, go to MEM_WAIT.
- MEM_WAIT: on dmem_rvalid_i, go to WRITEBACK.
- WRITEBACK:
  - rf_we_o = dec_rf_we_i.
  - pc_we_o = 1 and pc_sel_o = dec_j_i | (dec_b_i & branch_taken_i).
  - retire_o = 1 and instret_o increments.
  - Go to FETCH_REQ.
- HALT: absorbing until reset. All strobes and requests are 0.
- Decoder inputs are driven from the latched IR. They are sampled only in DECODE through WRITEBACK and must be stable there.
- Watchdog:
  - A wait counter increments each cycle in FETCH_REQ (only while halt_i is low), FETCH_WAIT, MEM_REQ and MEM_WAIT.
  - It clears on every state change.
  - When the counter reaches MEM_TIMEOUT without the exit condition, go to HALT and set bus_err_o. The exit condition has priority on the same cycle.
- instret_o wraps modulo 2^CNT_W.
- All strobe and request outputs are combinational from state plus inputs. state, counters and flags are registered.

## Timing
- Reset values:
  - state = FETCH_REQ
  - instret_o = 0
  - illegal_o = 0, bus_err_o = 0
  - wait counter = 0
  - With halt_i low, all other outputs are 0, except imem_req_o = 1 in FETCH_REQ.
- Reset mid-instruction aborts it with no writeback. Reset asserted in any state gives FETCH_REQ on the next edge after release.
- rvalid is only sampled in the WAIT states, so it comes at the earliest one cycle after the grant.
- Minimum latency with zero-wait memory (gnt in the request cycle, rvalid the following cycle):
  - ALU, branch or jump instruction: 5 cycles
  - Load or store: 7 cycles
- retire_o is one cycle per instruction, concurrent with pc_we_o.
- halt_i is honoured only in FETCH_REQ. An in-flight instruction always completes.
- A request stays asserted until granted. The sequencer never withdraws a request, except when halt_i rises in FETCH_REQ before the grant.
- Timeout in a state: HALT is entered on the edge where the wait count equals MEM_TIMEOUT. With MEM_TIMEOUT = 16 and no grant, HALT is reached 16 cycles after entering the state.

## Test plan
- ADD with zero-wait memory:
  - state_o goes 0,1,2,3,6,0.
  - rf_we_o=1, pc_sel_o=0 and retire_o=1 in cycle 5.
  - instret_o = 1.
- LW with gnt delayed 3 cycles and rvalid 2 cycles later:
  - dmem_req_o is held high for 4 cycles with dmem_we_o=0.
  - rf_we_o pulses in WRITEBACK.
  - Total latency is 12 cycles.
- Taken and not-taken branches:
  - BEQ with branch_taken_i=1 gives pc_sel_o=1 and rf_we_o=0.
  - BEQ with branch_taken_i=0 gives pc_sel_o=0.
  - SW gives dmem_we_o=1 and rf_we_o=0.
- dec_valid_i=0 in DECODE:
  - state_o goes to 7 and illegal_o=1.
  - Stays there for 100 cycles with no requests.
  - rst_ni pulse clears illegal_o and restarts at state 0.
- MEM_TIMEOUT=16 with dmem_gnt_i held at 0:
  - bus_err_o rises 16 cycles after entering MEM_REQ.
  - A grant arriving exactly on cycle 16 proceeds instead.
- halt_i high in FETCH_REQ for 20 cycles:
  - imem_req_o=0 and no timeout.
  - Release gives a normal fetch.
  - Preload instret_o=0xFFFFFFFF then retire one instruction: instret_o wraps to 0.
